// File: rtl/matrix_line_loader.sv
// Packs a byte stream into LANES-wide RAM lines for the dot-product engine, then
// kicks the engine once per load and holds off new loads until it reports done.
module matrix_line_loader #(
  parameter int unsigned LANES     = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_LINES = 256,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic                    clock,
  input  logic                    reset_l,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [LANES*DATA_W-1:0] wr_data,
  output logic                    engine_start,
  input  logic                    engine_done,
  output logic                    busy,
  output logic [7:0]              load_count
);

  localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned LineW = LANES * DATA_W;
  localparam logic [LaneW-1:0]  LastLane = LaneW'(LANES - 1);
  localparam logic [ADDR_W-1:0] LastLine = ADDR_W'(NUM_LINES - 1);

  typedef enum logic [2:0] {StIdle, StFill, StWrite, StKick, StWait} state_e;

  state_e             state_q, state_d;
  logic [LaneW-1:0]   lane_idx_q, lane_idx_d;
  logic [ADDR_W-1:0]  line_addr_q, line_addr_d;
  logic [LineW-1:0]   line_q, line_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [LineW-1:0]   wr_data_q, wr_data_d;
  logic [7:0]         load_count_q, load_count_d;

  logic beat;
  logic last_beat;

  assign beat      = (state_q == StFill) && in_valid;
  assign last_beat = beat && (lane_idx_q == LastLane);

  // State register
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StFill;
      StFill:  if (last_beat) state_d = StWrite;
      StWrite: state_d = (line_addr_q == LastLine) ? StKick : StFill;
      StKick:  state_d = StWait;
      StWait:  if (engine_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    lane_idx_d   = lane_idx_q;
    line_addr_d  = line_addr_q;
    line_d       = line_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    load_count_d = load_count_q;

    if (state_q == StIdle && start) begin
      lane_idx_d  = '0;
      line_addr_d = '0;
    end

    if (beat) begin
      line_d[int'(lane_idx_q)*DATA_W +: DATA_W] = in_data;
      lane_idx_d = (lane_idx_q == LastLane) ? '0 : lane_idx_q + LaneW'(1);
    end

    // Capture the completed line, including this cycle's byte, for the WRITE cycle.
    if (last_beat) begin
      wr_data_d = line_d;
      wr_addr_d = line_addr_q;
    end

    if (state_q == StWrite && line_addr_q != LastLine) begin
      line_addr_d = line_addr_q + ADDR_W'(1);
      lane_idx_d  = '0;
    end

    if (state_q == StWait && engine_done) begin
      load_count_d = load_count_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      lane_idx_q   <= '0;
      line_addr_q  <= '0;
      line_q       <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      load_count_q <= '0;
    end else begin
      lane_idx_q   <= lane_idx_d;
      line_addr_q  <= line_addr_d;
      line_q       <= line_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      load_count_q <= load_count_d;
    end
  end

  // Outputs decode the state register directly, so they carry no combinational input path.
  always_comb begin
    in_ready     = (state_q == StFill);
    wr_en        = (state_q == StWrite);
    engine_start = (state_q == StKick);
    busy         = (state_q != StIdle);
    wr_addr      = wr_addr_q;
    wr_data      = wr_data_q;
    load_count   = load_count_q;
  end

endmodule

// File: tb/tb_matrix_line_loader.sv
// Directed bench for matrix_line_loader: full loads, backpressure, protocol abuse,
// mid-load reset, and load_count wrap on a two-line instance.
module tb_matrix_line_loader;

  logic         clock = 1'b0;
  logic         reset_l;
  logic         start, in_valid, engine_done;
  logic [7:0]   in_data;
  logic         in_ready, wr_en, engine_start, busy;
  logic [7:0]   wr_addr, load_count;
  logic [127:0] wr_data;

  logic         start2;
  logic         in_valid2 = 1'b1;
  logic         engine_done2 = 1'b1;
  logic [7:0]   in_data2 = 8'h00;
  logic         in_ready2, wr_en2, engine_start2, busy2;
  logic [0:0]   wr_addr2;
  logic [7:0]   load_count2;
  logic [127:0] wr_data2;

  matrix_line_loader dut (
    .clock(clock), .reset_l(reset_l), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .engine_start(engine_start), .engine_done(engine_done),
    .busy(busy), .load_count(load_count)
  );

  matrix_line_loader #(.NUM_LINES(2), .ADDR_W(1)) dut2 (
    .clock(clock), .reset_l(reset_l), .start(start2), .in_valid(in_valid2),
    .in_data(in_data2), .in_ready(in_ready2), .wr_en(wr_en2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .engine_start(engine_start2), .engine_done(engine_done2),
    .busy(busy2), .load_count(load_count2)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitors for the main instance
  int           cyc = 0;
  int           wr_cnt = 0, es_cnt = 0, addr_bad = 0, gap_bad = 0;
  int           prev_wr_cyc = 0, last_wr_cyc = 0, es_cyc = 0;
  bit           have_prev = 0, check_gap = 0;
  logic [7:0]   exp_addr = 8'd0;
  logic [7:0]   last_addr = 8'd0;
  logic [127:0] last_data = '0;
  logic [127:0] img [256];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (wr_en) begin
      img[wr_addr] <= wr_data;
      wr_cnt       <= wr_cnt + 1;
      if (wr_addr != exp_addr) addr_bad <= addr_bad + 1;
      exp_addr     <= wr_addr + 8'd1;
      if (check_gap && have_prev && (cyc - prev_wr_cyc) != 17) gap_bad <= gap_bad + 1;
      prev_wr_cyc  <= cyc;
      have_prev    <= 1'b1;
      last_wr_cyc  <= cyc;
      last_addr    <= wr_addr;
      last_data    <= wr_data;
    end
    if (engine_start) begin
      es_cnt <= es_cnt + 1;
      es_cyc <= cyc;
    end
  end

  // Monitors for the two-line instance
  int         wr2_cnt = 0, es2_cnt = 0, since2 = 0, per_bad2 = 0, inc_bad2 = 0;
  bit         saw255 = 0;
  logic [7:0] prev_lc2 = 8'd0;
  logic       exp_addr2 = 1'b0;

  always @(negedge clock) begin
    if (wr_en2) begin
      wr2_cnt   <= wr2_cnt + 1;
      since2    <= since2 + 1;
      exp_addr2 <= ~wr_addr2[0];
      if (wr_addr2[0] != exp_addr2 || wr_data2 != '0) per_bad2 <= per_bad2 + 1;
    end
    if (engine_start2) begin
      es2_cnt <= es2_cnt + 1;
      since2  <= 0;
      if (since2 != 2) per_bad2 <= per_bad2 + 1;
    end
    if (in_ready2 && !busy2) per_bad2 <= per_bad2 + 1;
    if (load_count2 != prev_lc2) begin
      if (load_count2 != prev_lc2 + 8'd1) inc_bad2 <= inc_bad2 + 1;
      if (load_count2 == 8'd255) saw255 <= 1'b1;
      prev_lc2 <= load_count2;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bp);
    bit done = 0;
    int guard = 0;
    while (!done) begin
      @(negedge clock);
      if (bp && $urandom_range(1, 0) == 0) begin
        in_valid = 1'b0;
        in_data  = 'x;
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        done     = in_ready;
      end
      guard++;
      if (guard > 200) begin
        check("send_timeout", 1'b1, 1'b0);
        $fatal(1, "bench aborted: loader stopped accepting bytes");
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clock) engine_done = 1'b1;
    @(negedge clock) engine_done = 1'b0;
  endtask

  task automatic wait_es(input string tag, input int target, input int budget);
    int n = 0;
    while (es_cnt < target && n < budget) begin
      @(posedge clock);
      n++;
    end
    check(tag, es_cnt >= target, 1'b1);
    @(negedge clock);
  endtask

  function automatic int bad_lines();
    int n = 0;
    logic [127:0] e;
    for (int l = 0; l < 256; l++) begin
      for (int i = 0; i < 16; i++) e[i*8 +: 8] = 8'((16 * l + i) & 255);
      if (img[l] !== e) n++;
    end
    return n;
  endfunction

  localparam logic [127:0] Line0   = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] Line255 = 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0;
  localparam logic [127:0] NewLine = 128'h8F8E8D8C8B8A89888786858483828180;

  int base_wr, base_bad, base_es, n;

  initial begin
    reset_l = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    engine_done = 1'b0; start2 = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_data", wr_data, '0);
    @(negedge clock) reset_l = 1'b1;

    // Full load, no backpressure
    check_gap = 1;
    base_wr = wr_cnt; base_bad = addr_bad; base_es = es_cnt;
    pulse_start();
    check("t2_ready_after_start", in_ready, 1'b1);
    for (int k = 0; k < 4096; k++) send_byte(8'(k), 1'b0);
    @(negedge clock) in_valid = 1'b0;
    wait_es("t2_kick_seen", base_es + 1, 50);
    check_gap = 0;
    check("t2_writes", 32'(wr_cnt - base_wr), 32'd256);
    check("t2_addr_seq", 32'(addr_bad - base_bad), 32'd0);
    check("t2_gap17", 32'(gap_bad), 32'd0);
    check("t2_line0", img[0], Line0);
    check("t2_line255", img[255], Line255);
    check("t2_image", 32'(bad_lines()), 32'd0);
    check("t2_kick_count", 32'(es_cnt - base_es), 32'd1);
    check("t2_kick_latency", 32'(es_cyc - last_wr_cyc), 32'd1);
    check("t2_wait_busy", busy, 1'b1);
    check("t2_hold_addr", wr_addr, 8'd255);
    check("t2_hold_data", wr_data, Line255);

    // start during WAIT is ignored; engine_done completes the load
    pulse_start();
    repeat (2) @(negedge clock);
    check("t4_wait_start_busy", busy, 1'b1);
    check("t4_wait_start_ready", in_ready, 1'b0);
    check("t4_wait_start_count", load_count, 8'd0);
    check("t4_wait_start_kick", 32'(es_cnt - base_es), 32'd1);
    pulse_done();
    check("t4_done_idle", busy, 1'b0);
    check("t4_done_count", load_count, 8'd1);

    // Backpressure plus start/engine_done pulses during FILL
    base_wr = wr_cnt; base_bad = addr_bad; base_es = es_cnt;
    pulse_start();
    for (int k = 0; k < 4096; k++) begin
      if (k == 100) start = 1'b1;
      if (k == 102) start = 1'b0;
      if (k == 200) engine_done = 1'b1;
      if (k == 203) engine_done = 1'b0;
      send_byte(8'(k), 1'b1);
    end
    @(negedge clock) in_valid = 1'b0;
    wait_es("t3_kick_seen", base_es + 1, 50);
    check("t3_writes", 32'(wr_cnt - base_wr), 32'd256);
    check("t3_addr_seq", 32'(addr_bad - base_bad), 32'd0);
    check("t3_image", 32'(bad_lines()), 32'd0);
    check("t3_kick_count", 32'(es_cnt - base_es), 32'd1);
    check("t4_fill_abuse_count", load_count, 8'd1);
    pulse_done();
    check("t4_done_count2", load_count, 8'd2);

    // Reset after line 3 lane 7, then a fresh load
    pulse_start();
    for (int k = 0; k < 56; k++) send_byte(8'(k), 1'b0);
    @(negedge clock) in_valid = 1'b0;
    base_wr = wr_cnt;
    #2 reset_l = 1'b0;
    #1;
    check("t1_in_ready", in_ready, 1'b0);
    check("t1_wr_en", wr_en, 1'b0);
    check("t1_engine_start", engine_start, 1'b0);
    check("t1_busy", busy, 1'b0);
    check("t1_load_count", load_count, 8'd0);
    check("t1_wr_addr", wr_addr, 8'd0);
    repeat (2) @(negedge clock);
    reset_l = 1'b1;
    repeat (3) @(negedge clock);
    check("t5_no_write_after_reset", 32'(wr_cnt - base_wr), 32'd0);
    pulse_start();
    for (int k = 0; k < 16; k++) send_byte(8'h80 + 8'(k), 1'b0);
    @(negedge clock) in_valid = 1'b0;
    n = 0;
    while (wr_cnt == base_wr && n < 20) begin
      @(posedge clock);
      n++;
    end
    @(negedge clock);
    check("t5_write_seen", 32'(wr_cnt - base_wr), 32'd1);
    check("t5_first_addr", last_addr, 8'd0);
    check("t5_first_data", last_data, NewLine);
    #2 reset_l = 1'b0;
    @(negedge clock) reset_l = 1'b1;

    // Two-line instance: 256 back-to-back loads
    start2 = 1'b1;
    n = 0;
    while (es2_cnt < 256 && n < 12000) begin
      @(posedge clock);
      n++;
    end
    #1 start2 = 1'b0;
    repeat (5) @(negedge clock);
    check("t6_kicks", 32'(es2_cnt), 32'd256);
    check("t6_writes", 32'(wr2_cnt), 32'd512);
    check("t6_per_load", 32'(per_bad2), 32'd0);
    check("t6_increments", 32'(inc_bad2), 32'd0);
    check("t6_saw255", saw255, 1'b1);
    check("t6_wrapped", load_count2, 8'd0);
    check("t6_idle", busy2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
